hack_fetch_unit: RTL and testbench

Instruction-fetch and program-counter stage of the Hack CPU, directly upstream of the instruction decoder/control unit. It owns the 15-bit PC, drives a synchronous instruction ROM, latches the fetched word into a held instruction register that feeds the decoder, and resolves conditional jumps from ALU flags. It supports free-run and single-step modes on the Basys3 board, and detects the canonical Hack end-of-program loop.

---
 rtl/hack_pkg.sv | 25 ++
 rtl/hack_jump_eval.sv | 19 +
 rtl/hack_fetch_unit.sv | 108 ++++++++++
 tb/tb_hack_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: fetch FSM states, address width and
// instruction field positions used by the fetch stage and the control unit.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;

  // Instruction field positions
  localparam int C_BIT   = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int JLT_BIT = 2;   // jump if negative
  localparam int JEQ_BIT = 1;   // jump if zero
  localparam int JGT_BIT = 0;   // jump if positive

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } fetch_state_t;

  // True when the word is an A-instruction (load constant into A)
  function automatic logic is_a_instr(input logic [15:0] word);
    return ~word[C_BIT];
  endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump resolution for a Hack C-instruction from ALU flags.
// Also reused by the control unit to display the PC-load decision.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic       c_flag,
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // A-instructions never jump; C-instructions jump when any enabled
  // condition (lt / eq / gt) matches the current ALU result.
  assign take = c_flag & ((jump[JLT_BIT] & ng) |
                          (jump[JEQ_BIT] & zr) |
                          (jump[JGT_BIT] & ~zr & ~ng));

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch / PC stage: owns the PC, drives the synchronous ROM,
// holds the instruction for the decoder, resolves jumps and flags the
// canonical "@N; 0;JMP" end-of-program loop.
module hack_fetch_unit
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = HACK_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic [ADDR_W-1:0] a_val,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [15:0]       instr,
  output logic              exec,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              take;
  logic              exec_en;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_prev;
  logic              halt_hit;

  // History of the previously executed instruction for halt detection
  logic              prev_a_valid;
  logic [ADDR_W-1:0] prev_a_val;

  hack_jump_eval u_jump_eval (
    .c_flag (instr[C_BIT]),
    .jump   (instr[2:0]),
    .zr     (alu_zr),
    .ng     (alu_ng),
    .take   (take)
  );

  assign exec_en  = (state == ST_EXEC);
  assign exec     = exec_en;
  assign busy     = (state != ST_IDLE);
  // The PC only moves at the EXEC edge, so it is the fetch address in
  // every state that issues a ROM read.
  assign rom_addr = pc;
  assign pc_inc   = pc + ONE;
  assign pc_prev  = pc - ONE;

  // End-of-program loop: a taken jump back to pc-1 where pc-1 held the
  // A-instruction that loaded exactly that target.
  assign halt_hit = take & (a_val == pc_prev) & prev_a_valid & (prev_a_val == pc_prev);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; step only matters while idle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (run || step) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = run ? ST_FETCH : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Instruction register: captures ROM data one cycle after the fetch address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= 16'h0000;
    end else if (state == ST_DECODE) begin
      instr <= rom_data;
    end
  end

  // PC update, sticky halt flag and previous-instruction history at EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      halted       <= 1'b0;
      prev_a_valid <= 1'b0;
      prev_a_val   <= '0;
    end else if (exec_en) begin
      pc           <= take ? a_val : pc_inc;
      prev_a_valid <= is_a_instr(instr);
      prev_a_val   <= instr[ADDR_W-1:0];
      if (halt_hit) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Self-checking bench for hack_fetch_unit: directed scenarios followed by
// randomized programs, checked against an instruction-level model.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic [14:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic [14:0] a_val;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] instr;
  logic        exec;
  logic [14:0] pc;
  logic        busy;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rom [0:32767];
  logic [14:0] a_reg = 15'h0000;
  bit          rand_flags = 1'b0;

  hack_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .a_val    (a_val),
    .alu_zr   (alu_zr),
    .alu_ng   (alu_ng),
    .instr    (instr),
    .exec     (exec),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Minimal datapath: A-instructions load the A register on exec
  always @(posedge clk) if (exec && !instr[15]) a_reg <= instr[14:0];
  assign a_val = a_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: jump decision from the ALU outcome class (one of lt/eq/gt)
  function automatic logic ref_take(input logic [15:0] w, input logic zr, input logic ng);
    logic [2:0] outcome;
    outcome = ng ? 3'b100 : (zr ? 3'b010 : 3'b001);
    if (!w[15]) return 1'b0;
    return (w[2:0] & outcome) != 3'b000;
  endfunction

  // Random ALU flags, held steady through each EXEC cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rand_flags && !exec) begin
        case ($urandom_range(0, 2))
          0: begin alu_zr = 1'b0; alu_ng = 1'b0; end
          1: begin alu_zr = 1'b1; alu_ng = 1'b0; end
          default: begin alu_zr = 1'b0; alu_ng = 1'b1; end
        endcase
      end
    end
  end

  // Instruction-level model checked at every executed instruction
  logic [14:0] mpc, mprev_a, mpm1;
  bit          mprev_valid, mhalt, pending, run_at_exec, run_held, last_valid, tk;
  int          cyc = 0, last_cyc = 0, exec_count = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mpc = 15'h0000; mhalt = 0; mprev_valid = 0; pending = 0;
      last_valid = 0; run_held = 0;
    end else begin
      if (pending) begin
        check("pc_after_exec", pc, mpc);
        check("halted_after_exec", halted, mhalt);
        check("exec_one_cycle", exec, 0);
        check("busy_after_exec", busy, run_at_exec);
        pending = 0;
      end
      if (!run) run_held = 0;
      if (exec) begin
        check("exec_pc", pc, mpc);
        check("exec_instr", instr, rom[mpc]);
        if (last_valid && run_held) check("exec_gap", cyc - last_cyc, 3);
        tk   = ref_take(rom[mpc], alu_zr, alu_ng);
        mpm1 = mpc - 15'd1;
        $display("exec pc=%04h instr=%04h a=%04h zr=%0d ng=%0d take=%0d",
                 mpc, rom[mpc], a_val, alu_zr, alu_ng, tk);
        if (tk && a_val == mpm1 && mprev_valid && mprev_a == mpm1) mhalt = 1;
        mprev_valid = !rom[mpc][15];
        mprev_a     = rom[mpc][14:0];
        mpc         = tk ? a_val : mpc + 15'd1;
        run_at_exec = run; run_held = run; last_cyc = cyc; last_valid = 1;
        pending = 1; exec_count++;
      end
    end
  end

  task automatic do_step();
    int n;
    @(posedge clk); #2 step = 1'b1;
    @(posedge clk); #2 step = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 10);
    if (busy) check("step_timeout", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, first_n, p;
    logic [15:0] seen_instr;
    rst = 1'b1; run = 1'b0; step = 1'b0; alu_zr = 1'b0; alu_ng = 1'b0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_exec", exec, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_halted", halted, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Walk pc up to 5, then reset during FETCH
    for (int i = 0; i < 5; i++) rom[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) do_step();
    check("walk_pc", pc, 5);
    @(posedge clk); #2 step = 1'b1;
    @(posedge clk); #2 step = 1'b0;
    @(negedge clk);
    check("fetch_busy", busy, 1);
    check("fetch_rom_addr", rom_addr, 5);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_exec", exec, 0);
    check("async_rst_instr", instr, 16'h0000);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (exec) cnt++; end
    check("no_exec_in_rst", cnt, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Single step with a second step ignored while busy
    rom[0] = 16'h0007;
    @(posedge clk); #2 step = 1'b1;
    @(posedge clk); #2 step = 1'b0;
    @(negedge clk);
    check("step_rom_addr", rom_addr, 0);
    check("step_busy", busy, 1);
    #1 step = 1'b1;
    @(posedge clk); #2 step = 1'b0;
    cnt = 0; first_n = 0; seen_instr = 16'h0000;
    for (n = 2; n <= 8; n++) begin
      @(negedge clk);
      if (exec) begin
        cnt++;
        if (first_n == 0) begin first_n = n; seen_instr = instr; end
      end
    end
    check("step_latency", first_n, 3);
    check("step_exec_count", cnt, 1);
    check("step_instr", seen_instr, 16'h0007);
    check("step_pc", pc, 1);
    check("step_idle", busy, 0);

    // Conditional jump D;JEQ with A = 0x0010
    rom[1] = 16'h0010; rom[2] = 16'hE302; rom[16] = 16'hE302;
    do_step();
    alu_zr = 1'b1; alu_ng = 1'b0;
    do_step();
    check("jeq_taken_pc", pc, 16'h0010);
    alu_zr = 1'b0; alu_ng = 1'b0;
    do_step();
    check("jeq_not_taken_pc", pc, 16'h0011);

    // Unconditional jump to the top address, then wrap
    rom[17] = 16'h7FFF; rom[18] = 16'hEA87; rom[32767] = 16'h0005;
    do_step();
    do_step();
    check("jmp_top_pc", pc, 16'h7FFF);
    do_step();
    check("wrap_pc", pc, 0);

    // Run into the end-of-program loop @4; 0;JMP
    for (int i = 0; i < 4; i++) rom[i] = 16'(16'h0100 + i);
    rom[4] = 16'h0004; rom[5] = 16'hEA87;
    do_reset();
    rand_flags = 1'b1;
    @(posedge clk); #2 run = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!halted && n < 60);
    check("halt_seen", halted, 1);
    check("halt_pc", pc, 4);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (exec) cnt++; end
    check("run_after_halt_execs", cnt, 4);
    check("halt_sticky", halted, 1);

    // Drop run during DECODE: the instruction completes, then idle
    n = 0;
    do begin @(negedge clk); n++; end while (!exec && n < 10);
    check("drop_sync", exec, 1);
    @(posedge clk);
    @(posedge clk); #2 run = 1'b0;
    p = pc;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (exec) cnt++; end
    check("drop_exec_count", cnt, 1);
    check("drop_idle", busy, 0);
    check("drop_pc", pc, (p == 4) ? 5 : 4);

    // Randomized programs with random run / step activity
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 9) < 4) rom[i] = 16'($urandom_range(0, 127));
      else rom[i] = 16'hE000 | (16'($urandom) & 16'h1FF8) | 16'($urandom_range(0, 7));
    end
    for (int i = 30; i < 126; i += 32) begin
      rom[i] = 16'(i); rom[i + 1] = 16'hEA87;
    end
    do_reset();
    cnt = exec_count;
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 29) == 0) run = ~run;
      step = ($urandom_range(0, 5) == 0);
    end
    run = 1'b0; step = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 10);
    check("rand_final_idle", busy, 0);
    check("rand_execs_seen", (exec_count - cnt) > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
